fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl_pkg.sv | 15 +
 rtl/fifo_out_buf.sv | 57 +++++
 rtl/fifo_read_ctrl.sv | 87 ++++++++
 tb/tb_fifo_read_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the FIFO read-side output controller:
// occupancy state encoding and default widths.
package fifo_read_ctrl_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  // Number of words currently held in the 2-entry output buffer
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } occ_state_e;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer. Entry 0 is always the head word presented
// downstream; entry 1 only ever holds the word queued behind it.
module fifo_out_buf
  import fifo_read_ctrl_pkg::*;
#(
  parameter int Data_width = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  occ_state_e            state,
  input  logic                  push,
  input  logic                  pop,
  input  logic [Data_width-1:0] wr_data,
  output logic [Data_width-1:0] head
);

  logic [Data_width-1:0] entry0_q, entry0_d;
  logic [Data_width-1:0] entry1_q, entry1_d;

  // Decide where a pushed word lands and shift entry 1 forward on a pop
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case (state)
      EMPTY: begin
        if (push) entry0_d = wr_data;
      end
      ONE: begin
        if (push && pop) begin
          entry0_d = wr_data;
        end else if (push) begin
          entry1_d = wr_data;
        end
      end
      TWO: begin
        if (pop) entry0_d = entry1_q;
      end
      default: begin
        entry0_d = entry0_q;
      end
    endcase
  end

  // Storage registers, cleared on reset so no stale word survives
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  assign head = entry0_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: pulls words out of the FIFO memory into a
// 2-entry output buffer and hands them downstream with valid/ready.
// Rinc depends only on registered state and FIFO-side inputs, so there
// is no combinational path from Out_ready back into the FIFO.
module fifo_read_ctrl
  import fifo_read_ctrl_pkg::*;
#(
  parameter int Data_width  = DEFAULT_DATA_WIDTH,
  parameter int Count_width = DEFAULT_COUNT_WIDTH
) (
  input  logic                   Rclk,
  input  logic                   Rrst,
  input  logic                   Enable,
  input  logic                   Rempty,
  input  logic [Data_width-1:0]  Rdata,
  output logic                   Rinc,
  input  logic                   Out_ready,
  output logic                   Out_valid,
  output logic [Data_width-1:0]  Out_data,
  output logic [Count_width-1:0] Pop_count,
  output logic                   Busy
);

  occ_state_e             state_q, state_d;
  logic [Count_width-1:0] pop_count_q, pop_count_d;
  logic                   push;
  logic                   pop;

  // Handshake terms: a push is a FIFO read, a pop is a downstream accept
  always_comb begin
    push = ~Rrst & Enable & ~Rempty & (state_q != TWO);
    pop  = (state_q != EMPTY) & Out_ready;
  end

  // Occupancy next-state and delivered-word counter update
  always_comb begin
    state_d     = state_q;
    pop_count_d = pop_count_q + Count_width'(pop);
    case (state_q)
      EMPTY: begin
        if (push) state_d = ONE;
      end
      ONE: begin
        if (push && !pop) begin
          state_d = TWO;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) state_d = ONE;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge Rclk) begin
    if (Rrst) begin
      state_q     <= EMPTY;
      pop_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pop_count_q <= pop_count_d;
    end
  end

  fifo_out_buf #(
    .Data_width(Data_width)
  ) u_out_buf (
    .clk    (Rclk),
    .rst    (Rrst),
    .state  (state_q),
    .push   (push),
    .pop    (pop),
    .wr_data(Rdata),
    .head   (Out_data)
  );

  assign Rinc      = push;
  assign Out_valid = (state_q != EMPTY);
  assign Pop_count = pop_count_q;
  assign Busy      = (state_q != EMPTY) | push;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a queue scoreboard: every word
// the FIFO hands over is queued and must come back out in order.
module tb_fifo_read_ctrl;

  logic        Rclk;
  logic        Rrst;
  logic        Enable;
  logic        Rempty;
  logic [7:0]  Rdata;
  logic        Rinc;
  logic        Out_ready;
  logic        Out_valid;
  logic [7:0]  Out_data;
  logic [15:0] Pop_count;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl_q[$];
  logic [15:0] mdl_pcnt = '0;

  logic        samp_rinc;
  logic        samp_valid;
  logic [7:0]  samp_data;
  logic [15:0] samp_pcnt;
  logic        samp_busy;

  fifo_read_ctrl dut (
    .Rclk     (Rclk),
    .Rrst     (Rrst),
    .Enable   (Enable),
    .Rempty   (Rempty),
    .Rdata    (Rdata),
    .Rinc     (Rinc),
    .Out_ready(Out_ready),
    .Out_valid(Out_valid),
    .Out_data (Out_data),
    .Pop_count(Pop_count),
    .Busy     (Busy)
  );

  // Free-running read clock
  initial Rclk = 1'b0;
  always #5 Rclk = ~Rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic en, input logic empty,
                                input logic [7:0] data, input logic ready);
    Rrst      = rst;
    Enable    = en;
    Rempty    = empty;
    Rdata     = data;
    Out_ready = ready;
  endtask

  // One clock: sample and check mid-cycle, then advance the scoreboard
  task automatic check_output();
    logic       exp_rinc;
    logic       do_pop;
    logic       do_push;
    logic [7:0] push_word;
    @(negedge Rclk);
    samp_rinc  = Rinc;
    samp_valid = Out_valid;
    samp_data  = Out_data;
    samp_pcnt  = Pop_count;
    samp_busy  = Busy;
    exp_rinc   = !Rrst && Enable && !Rempty && (mdl_q.size() < 2);
    check("rinc", Rinc, exp_rinc);
    check("out_valid", Out_valid, mdl_q.size() > 0);
    if (mdl_q.size() > 0) check("out_data", Out_data, mdl_q[0]);
    check("pop_count", Pop_count, mdl_pcnt);
    check("busy", Busy, (mdl_q.size() > 0) || exp_rinc);
    do_pop    = (mdl_q.size() > 0) && Out_ready;
    do_push   = exp_rinc;
    push_word = Rdata;
    @(posedge Rclk);
    if (Rrst) begin
      mdl_q.delete();
      mdl_pcnt = '0;
    end else begin
      if (do_pop) begin
        void'(mdl_q.pop_front());
        mdl_pcnt = mdl_pcnt + 16'd1;
      end
      if (do_push) mdl_q.push_back(push_word);
    end
    #1;
  endtask

  initial begin
    int rinc_hits;

    // Reset with FIFO data offered: nothing may be read
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h5A, 1'b1);
    @(posedge Rclk);
    #1;
    check_output();
    check("rst_valid", samp_valid, 1'b0);
    check("rst_data", samp_data, 8'h00);
    check("rst_pcnt", samp_pcnt, 16'h0000);
    check("rst_rinc", samp_rinc, 1'b0);
    check("rst_busy", samp_busy, 1'b0);

    // First word latency
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1);
    check_output();
    check("lat_c0_rinc", samp_rinc, 1'b1);
    check("lat_c0_valid", samp_valid, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    check_output();
    check("lat_c1_valid", samp_valid, 1'b1);
    check("lat_c1_data", samp_data, 8'hA5);
    check_output();
    check("lat_c2_pcnt", samp_pcnt, 16'd1);
    check("lat_c2_valid", samp_valid, 1'b0);

    // Backpressure fills the buffer, then drains in order
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h11, 1'b0);
    check_output();
    check("bp_rinc0", samp_rinc, 1'b1);
    Rdata = 8'h22;
    check_output();
    check("bp_rinc1", samp_rinc, 1'b1);
    Rdata = 8'h33;
    check_output();
    check("bp_full_rinc", samp_rinc, 1'b0);
    check("bp_full_data", samp_data, 8'h11);
    check_output();
    check("bp_hold_data", samp_data, 8'h11);
    check("bp_hold_valid", samp_valid, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
    check_output();
    check("bp_out0", samp_data, 8'h11);
    check_output();
    check("bp_out1", samp_data, 8'h22);
    check_output();
    check("bp_empty", samp_valid, 1'b0);
    check("bp_pcnt", samp_pcnt, 16'd3);

    // Ten-word stream at full rate from a fresh reset
    apply_stimulus(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    check_output();
    rinc_hits = 0;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 8'h40 + i[7:0], 1'b1);
      check_output();
      if (samp_rinc) rinc_hits++;
    end
    check("stream_rinc", rinc_hits, 10);
    Rempty = 1'b1;
    check_output();
    check("stream_last", samp_data, 8'h49);
    check_output();
    check("stream_pcnt", samp_pcnt, 16'd10);

    // Enable drop while full: no new reads, buffered words still drain
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
    check_output();
    Rdata = 8'h88;
    check_output();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h99, 1'b0);
    check_output();
    check("en_off_rinc", samp_rinc, 1'b0);
    Out_ready = 1'b1;
    check_output();
    check("en_off_out0", samp_data, 8'h77);
    check_output();
    check("en_off_out1", samp_data, 8'h88);
    check("en_off_rinc2", samp_rinc, 1'b0);
    check("en_off_busy1", samp_busy, 1'b1);
    check_output();
    check("en_off_busy0", samp_busy, 1'b0);

    // Reset while full discards both words
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hC1, 1'b0);
    check_output();
    Rdata = 8'hC2;
    check_output();
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
    check_output();
    check("mrst_rinc", samp_rinc, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'hC4, 1'b1);
    check_output();
    check("mrst_valid", samp_valid, 1'b0);
    check("mrst_pcnt", samp_pcnt, 16'd0);
    check("mrst_rinc2", samp_rinc, 1'b0);

    // Stream until the counter reaches its top value, then one more pop
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      if (mdl_pcnt == 16'hFFFF) break;
      Rdata = i[7:0];
      check_output();
    end
    check("wrap_top", Pop_count, 16'hFFFF);
    Enable = 1'b0;
    check_output();
    check("wrap_pre", samp_pcnt, 16'hFFFF);
    check_output();
    check("wrap_zero", samp_pcnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
